// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Latency: one cycle from id_* to ex_*. The stall output is combinational in the same cycle.
// Backpressure: stall holds the PC and the IF/ID register for exactly one cycle, and a bubble enters EX.
//
// Ports:
//   clk, reset              rising-edge clock; asynchronous active-high reset
//   id_* (controls)         ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, ALUOp[1:0]
//   id_* (data)             pc, rd1, rd2, imm [DATA_W], rs1, rs2, rd [5], funct3 [3], funct7 [7]
//   id_valid                the decode slot holds a real instruction
//   ex_flush                a branch or jump was taken in EX, so the decode-stage instruction is killed
//   ex_*                    registered copies of every id_* input, including ex_valid
//   stall                   hold PC and IF/ID this cycle (load-use hazard, suppressed by ex_flush)
//   stall_cnt, flush_cnt    saturating 32-bit event counters, present only when ID_EX_BUBBLE_CNT_EN is defined
//
// Optional feature macro: ID_EX_BUBBLE_CNT_EN

module id_ex_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,

   // decode-stage control
   input  logic              id_ALUSrc,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_Branch,
   input  logic              id_JalrSel,
   input  logic [1:0]        id_ALUOp,

   // decode-stage data
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              id_valid,

   input  logic              ex_flush,

   // execute-stage control
   output logic              ex_ALUSrc,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_Branch,
   output logic              ex_JalrSel,
   output logic [1:0]        ex_ALUOp,

   // execute-stage data
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic              ex_valid,

   output logic              stall
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   logic hazard;
   logic bubble;

   // A load in EX whose destination matches a source of the decode instruction.
   // Because rd=x0 is excluded, a load into x0 never stalls.
   always_comb begin
      hazard = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   end

   // A flush kills the decode instruction anyway, so holding it would be pointless.
   // During reset the EX register is zero, so the hazard term is already low.
   // Gating with reset makes that zero independent of register timing.
   always_comb begin
      stall = hazard & ~ex_flush & ~reset;
   end

   // Any of the three conditions sends a bubble into EX.
   // After a bubble, ex_MemRead is 0, which clears the hazard, so a stall never exceeds one cycle.
   always_comb begin
      bubble = hazard | ex_flush | ~id_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ALUSrc   <= 1'b0;
         ex_MemtoReg <= 1'b0;
         ex_RegWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         ex_MemWrite <= 1'b0;
         ex_Branch   <= 1'b0;
         ex_JalrSel  <= 1'b0;
         ex_ALUOp    <= 2'b00;
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_rs1      <= 5'd0;
         ex_rs2      <= 5'd0;
         ex_rd       <= 5'd0;
         ex_funct3   <= 3'd0;
         ex_funct7   <= 7'd0;
      end else begin
         // Data fields are don't-care inside a bubble.
         // Loading them unconditionally keeps the enables off the wide datapath.
         ex_pc     <= id_pc;
         ex_rd1    <= id_rd1;
         ex_rd2    <= id_rd2;
         ex_imm    <= id_imm;
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_rd     <= id_rd;
         ex_funct3 <= id_funct3;
         ex_funct7 <= id_funct7;

         if (bubble) begin
            // ALUSrc and MemtoReg are cleared as well, so that a bubble is a clean NOP.
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_JalrSel  <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_valid    <= 1'b0;
         end else begin
            ex_ALUSrc   <= id_ALUSrc;
            ex_MemtoReg <= id_MemtoReg;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_Branch   <= id_Branch;
            ex_JalrSel  <= id_JalrSel;
            ex_ALUOp    <= id_ALUOp;
            ex_valid    <= 1'b1;
         end
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   // Saturating event counters: each edge adds at most one to each counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (ex_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_JalrSel;
   logic [1:0]    id_ALUOp;
   logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic [2:0]    id_funct3;
   logic [6:0]    id_funct7;
   logic          id_valid, ex_flush;
   logic          ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_JalrSel;
   logic [1:0]    ex_ALUOp;
   logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]    ex_rs1, ex_rs2, ex_rd;
   logic [2:0]    ex_funct3;
   logic [6:0]    ex_funct7;
   logic          ex_valid, stall;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0]   stall_cnt, flush_cnt;
`endif

   id_ex_stage #(.DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
      .id_JalrSel(id_JalrSel), .id_ALUOp(id_ALUOp),
      .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
      .id_valid(id_valid), .ex_flush(ex_flush),
      .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
      .ex_JalrSel(ex_JalrSel), .ex_ALUOp(ex_ALUOp),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .ex_valid(ex_valid), .stall(stall)
`ifdef ID_EX_BUBBLE_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld, flush;
      logic [1:0]  aluop;
      logic        regw, memr, memw, br, jalr;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc;
      logic        e_stall;   // expected stall while this row sits in decode
      logic        e_bubble;  // expected: EX holds a bubble after the edge
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic vld, input logic flush, input logic [1:0] aluop,
                               input logic regw, input logic memr, input logic memw,
                               input logic br, input logic jalr,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] pc, input logic e_stall, input logic e_bubble);
      vec_t v;
      v.vld = vld; v.flush = flush; v.aluop = aluop; v.regw = regw; v.memr = memr;
      v.memw = memw; v.br = br; v.jalr = jalr; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.pc = pc; v.e_stall = e_stall; v.e_bubble = e_bubble;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      id_valid    = v.vld;
      ex_flush    = v.flush;
      id_ALUOp    = v.aluop;
      id_RegWrite = v.regw;
      id_MemRead  = v.memr;
      id_MemWrite = v.memw;
      id_Branch   = v.br;
      id_JalrSel  = v.jalr;
      id_ALUSrc   = v.memr | v.memw;
      id_MemtoReg = v.memr;
      id_rs1      = v.rs1;
      id_rs2      = v.rs2;
      id_rd       = v.rd;
      id_pc       = v.pc;
      id_rd1      = v.pc + 32'd1;
      id_rd2      = v.pc + 32'd2;
      id_imm      = v.pc + 32'd3;
      id_funct3   = v.rd[2:0];
      id_funct7   = {2'b00, v.rd};
   endtask

   // Apply a row, check stall mid-cycle, clock, then check EX contents.
   task automatic run_vec(input int i, input vec_t v);
      apply(v);
      #3;
      chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, v.e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, ~v.e_bubble});
      if (v.e_bubble) begin
         chk($sformatf("v%0d bubble_ctl", i),
             {26'd0, ex_ALUOp, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_JalrSel}, 32'd0);
      end else begin
         chk($sformatf("v%0d ctl", i),
             {26'd0, ex_ALUOp, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_JalrSel},
             {26'd0, v.aluop, v.regw, v.memr, v.memw, v.br, v.jalr});
         chk($sformatf("v%0d alusrc_m2r", i), {30'd0, ex_ALUSrc, ex_MemtoReg},
             {30'd0, v.memr | v.memw, v.memr});
         chk($sformatf("v%0d pc", i), ex_pc, v.pc);
         chk($sformatf("v%0d rd1", i), ex_rd1, v.pc + 32'd1);
         chk($sformatf("v%0d rd2", i), ex_rd2, v.pc + 32'd2);
         chk($sformatf("v%0d imm", i), ex_imm, v.pc + 32'd3);
         chk($sformatf("v%0d regs", i), {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, v.rs1, v.rs2, v.rd});
         chk($sformatf("v%0d funct", i), {22'd0, ex_funct3, ex_funct7},
             {22'd0, v.rd[2:0], 2'b00, v.rd});
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " ctl"}, {22'd0, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                           ex_Branch, ex_JalrSel, ex_ALUOp, ex_valid}, 32'd0);
      chk({name, " pc"}, ex_pc, 32'd0);
      chk({name, " rd1"}, ex_rd1, 32'd0);
      chk({name, " rd2"}, ex_rd2, 32'd0);
      chk({name, " imm"}, ex_imm, 32'd0);
      chk({name, " regs"}, {7'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}, 32'd0);
      chk({name, " stall"}, {31'd0, stall}, 32'd0);
   endtask

   initial begin
      //                vld fl aluop  rw mr mw br jr  rs1 rs2 rd  pc       stl bub
      vecs[0]  = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 2, 3, 32'h100, 0, 0); // add x3,x1,x2
      vecs[1]  = mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 5, 32'h104, 0, 0); // lw x5
      vecs[2]  = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 5, 6, 32'h108, 1, 1); // rs2=x5: stall
      vecs[3]  = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 5, 6, 32'h108, 0, 0); // held consumer passes
      vecs[4]  = mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 2, 0, 0, 32'h10C, 0, 0); // lw x0
      vecs[5]  = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 7, 32'h110, 0, 0); // rs1=x0: no stall
      vecs[6]  = mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 5, 32'h114, 0, 0); // lw x5
      vecs[7]  = mk(1, 1, 2'b10, 1, 0, 0, 0, 0, 5, 1, 8, 32'h118, 0, 1); // flush + hazard
      vecs[8]  = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 5, 5, 9, 32'h11C, 0, 0); // next passes
      vecs[9]  = mk(0, 0, 2'b11, 1, 1, 1, 1, 1, 3, 4, 10, 32'h120, 0, 1); // id_valid=0
      vecs[10] = mk(1, 0, 2'b11, 1, 0, 0, 0, 1, 1, 0, 1, 32'h124, 0, 0); // jalr
      vecs[11] = mk(1, 0, 2'b01, 0, 0, 0, 1, 0, 1, 2, 0, 32'h128, 0, 0); // branch
      vecs[12] = mk(1, 0, 2'b00, 0, 0, 1, 0, 0, 1, 2, 0, 32'h12C, 0, 0); // sw
      vecs[13] = mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 5, 32'h130, 0, 0); // lw x5
      vecs[14] = mk(0, 0, 2'b10, 1, 0, 0, 0, 0, 5, 5, 11, 32'h134, 0, 1); // invalid: no stall
      vecs[15] = mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 3, 0, 2, 32'h138, 0, 0); // lw x2
      vecs[16] = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 2, 7, 12, 32'h13C, 1, 1); // rs1=x2: stall

      reset = 1'b1;
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
      #12;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset mid-stall: lw x5 in EX, consumer in decode, then reset between edges.
      run_vec(100, mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 5, 32'h200, 0, 0));
      apply(mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 5, 0, 6, 32'h204, 0, 0));
      #2;
      chk("rst_mid pre_stall", {31'd0, stall}, 32'd1);
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_rel stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_rel pass", {26'd0, ex_valid, ex_rd}, {26'd0, 1'b1, 5'd6});

`ifdef ID_EX_BUBBLE_CNT_EN
      reset = 1'b1;
      #1;
      chk("cnt reset", stall_cnt | flush_cnt, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         run_vec(200 + 3 * k, mk(1, 0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 5, 32'h300, 0, 0));
         run_vec(201 + 3 * k, mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 5, 0, 6, 32'h304, 1, 1));
         run_vec(202 + 3 * k, mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 5, 0, 6, 32'h304, 0, 0));
      end
      run_vec(210, mk(1, 1, 2'b10, 1, 0, 0, 0, 0, 1, 2, 3, 32'h308, 0, 1));
      run_vec(211, mk(1, 1, 2'b10, 1, 0, 0, 0, 0, 1, 2, 3, 32'h30C, 0, 1));
      chk("stall_cnt", stall_cnt, 32'd3);
      chk("flush_cnt", flush_cnt, 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
